// File: rtl/dmem_stream_ctrl_if.sv
// dmem_stream_ctrl_if: groups the input stream, output stream and dmem port
// signals used by dmem_stream_ctrl.
//   s_valid/s_ready/s_data : input stream (LOAD source)
//   m_valid/m_ready/m_data : output stream (DUMP sink)
//   mem_wr/mem_addr/mem_din/mem_dout : dmem single port, dout is combinational
// master modport: the controller side; slave modport: stream/dmem side.
interface dmem_stream_ctrl_if #(
  parameter int Nloc  = 64,
  parameter int Dbits = 32
);
  localparam int AW = $clog2(Nloc);

  logic             s_valid;
  logic             s_ready;
  logic [Dbits-1:0] s_data;
  logic             m_valid;
  logic             m_ready;
  logic [Dbits-1:0] m_data;
  logic             mem_wr;
  logic [AW-1:0]    mem_addr;
  logic [Dbits-1:0] mem_din;
  logic [Dbits-1:0] mem_dout;

  modport master (
    input  s_valid, s_data, m_ready, mem_dout,
    output s_ready, m_valid, m_data, mem_wr, mem_addr, mem_din
  );

  modport slave (
    output s_valid, s_data, m_ready, mem_dout,
    input  s_ready, m_valid, m_data, mem_wr, mem_addr, mem_din
  );
endinterface

// File: rtl/dmem_stream_ctrl.sv
// dmem_stream_ctrl: block mover between valid/ready streams and dmem.
//   LOAD: words from the input stream are written to consecutive locations.
//   DUMP: consecutive locations are read through dmem's combinational read
//         path and presented on the output stream.
// Ports:
//   clock, reset_n          : rising-edge clock, async active-low reset
//   start, mode             : start request (sampled in IDLE), 0=LOAD 1=DUMP
//   base_addr, count        : first location and word count (saturates at Nloc)
//   busy, done              : busy in LOAD/DUMP, one-cycle done pulse
//   bus (master modport)    : streams and dmem port
module dmem_stream_ctrl #(
  parameter int Nloc  = 64,
  parameter int Dbits = 32,
  localparam int AW   = $clog2(Nloc)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   count,
  output logic          busy,
  output logic          done,
  dmem_stream_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DUMP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic [AW-1:0]    r_cur_addr;
  logic [AW:0]      r_remaining;
  logic             r_mode;

  logic [AW:0]      w_count_sat;
  logic [AW-1:0]    w_next_addr;
  logic             w_xfer;

  logic             w_busy;
  logic             w_done;
  logic             w_s_ready;
  logic             w_m_valid;
  logic [Dbits-1:0] w_m_data;
  logic             w_mem_wr;
  logic [AW-1:0]    w_mem_addr;
  logic [Dbits-1:0] w_mem_din;

  // Count saturation, wrapping address increment and handshake detection.
  always_comb begin
    if (count > (AW+1)'(Nloc)) begin
      w_count_sat = (AW+1)'(Nloc);
    end else begin
      w_count_sat = count;
    end

    // Explicit wrap so a non-power-of-two Nloc still cycles correctly.
    if (r_cur_addr == AW'(Nloc - 1)) begin
      w_next_addr = {AW{1'b0}};
    end else begin
      w_next_addr = r_cur_addr + AW'(1);
    end

    // s_ready is 1 throughout LOAD and m_valid is 1 throughout DUMP, so a
    // handshake reduces to the far side's valid/ready.
    if (r_mode) begin
      w_xfer = (r_state == ST_DUMP) && bus.m_ready;
    end else begin
      w_xfer = (r_state == ST_LOAD) && bus.s_valid;
    end
  end

  // Transfer FSM with its latched address, remaining count and mode.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_cur_addr  <= {AW{1'b0}};
      r_remaining <= {(AW+1){1'b0}};
      r_mode      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_cur_addr  <= base_addr;
            r_remaining <= w_count_sat;
            r_mode      <= mode;
            if (w_count_sat == {(AW+1){1'b0}}) begin
              r_state <= ST_DONE;
            end else if (mode) begin
              r_state <= ST_DUMP;
            end else begin
              r_state <= ST_LOAD;
            end
          end
        end
        ST_LOAD, ST_DUMP: begin
          if (w_xfer) begin
            r_cur_addr  <= w_next_addr;
            r_remaining <= r_remaining - (AW+1)'(1);
            if (r_remaining == (AW+1)'(1)) begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Output decode from the state register; data paths pass straight through
  // so the write and the read are zero-latency.
  always_comb begin
    w_busy     = 1'b0;
    w_done     = 1'b0;
    w_s_ready  = 1'b0;
    w_m_valid  = 1'b0;
    w_m_data   = {Dbits{1'b0}};
    w_mem_wr   = 1'b0;
    w_mem_addr = {AW{1'b0}};
    w_mem_din  = {Dbits{1'b0}};
    case (r_state)
      ST_LOAD: begin
        w_busy     = 1'b1;
        w_s_ready  = 1'b1;
        w_mem_addr = r_cur_addr;
        w_mem_din  = bus.s_data;
        w_mem_wr   = bus.s_valid;
      end
      ST_DUMP: begin
        w_busy     = 1'b1;
        w_m_valid  = 1'b1;
        w_mem_addr = r_cur_addr;
        w_m_data   = bus.mem_dout;
      end
      ST_DONE: begin
        w_done = 1'b1;
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  assign busy         = w_busy;
  assign done         = w_done;
  assign bus.s_ready  = w_s_ready;
  assign bus.m_valid  = w_m_valid;
  assign bus.m_data   = w_m_data;
  assign bus.mem_wr   = w_mem_wr;
  assign bus.mem_addr = w_mem_addr;
  assign bus.mem_din  = w_mem_din;

endmodule
